nsu_vc_pack_buffer: RTL and testbench
=====================================

NSU_VC_PACK_BUFFER -- requirements
Module: nsu_vc_pack_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128, flit payload width.
REQ-002 SHALL have parameter VC_NUM, default 4, virtual channels (>=2, power of 2).
REQ-003 SHALL have parameter DEPTH, default 16, flits per VC buffer (power of 2, >=4).
REQ-004 SHALL have parameters HEAD_CODE_H, default 4'hA, and TAIL_CODE_H, default 4'hC, 4-bit check codes in flit bits [DATA_WIDTH-1:DATA_WIDTH-4].
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 noc_clk  in  1  sole clock, all logic on rising edge.
REQ-007 noc_rst  in  1  synchronous active-high reset.
REQ-008 in_data  in  DATA_WIDTH  write flit; in_valid in 1; in_head in 1; in_tail in 1; in_vc in clog2(VC_NUM) target VC.
REQ-009 in_ready  out  1  write accepted when in_valid&&in_ready.
REQ-010 out_data  out  DATA_WIDTH; out_head, out_tail out 1; out_vc out clog2(VC_NUM); out_valid out 1.
REQ-011 out_ready  in  1  downstream accepts when out_valid&&out_ready.
REQ-012 vc_full, vc_empty  out  VC_NUM  per-VC status; err_code out 1 one-cycle pulse; pkt_drop_cnt out 16 saturating dropped-packet count.

Function
REQ-013 SHALL keep per-VC circular flit FIFO (flit, head, tail), write/read pointers with extra wrap bit; full = pointers equal except wrap bit.
REQ-014 in_ready SHALL equal ~vc_full[in_vc] and SHALL be combinational from in_vc.
REQ-015 Head flit SHALL be written only if its code bits equal HEAD_CODE_H; tail flit only if its code bits equal TAIL_CODE_H; a single-flit packet (head&&tail) SHALL carry HEAD_CODE_H.
REQ-016 On code mismatch, or head received while that VC is mid-packet, or body flit while VC idle: SHALL pulse err_code next cycle, enter DROP for that VC, and discard flits up to and including next tail; pkt_drop_cnt += 1 (saturates at 16'hFFFF); in_ready stays as REQ-014.
REQ-017 A partially written packet already in the FIFO when DROP is entered SHALL be rolled back (write pointer restored to packet-start pointer).
REQ-018 Per-VC packet counter (width clog2(DEPTH)+1) SHALL +1 when a tail is written, -1 when a tail is read, unchanged when both occur same cycle.
REQ-019 Store-and-forward: a VC is eligible for output only when its packet counter > 0.
REQ-020 Output FSM states IDLE and LOCK. IDLE: round-robin grant among eligible VCs, priority starting after last granted VC; grant moves to LOCK same cycle (out_valid asserted in the grant cycle).
REQ-021 LOCK: out_* SHALL show the head-of-FIFO flit of the locked VC with out_valid=1; on accepted tail return to IDLE; no interleaving of VCs within a packet.
REQ-022 out_valid SHALL not drop while out_ready is low (data stable until accepted).
REQ-023 Latency: tail written in cycle N -> out_valid for that packet's head no earlier than cycle N+1, at N+1 if output IDLE and no higher-priority VC eligible.
REQ-024 Simultaneous write and read on the same VC SHALL both succeed when FIFO non-full (full VC: read frees slot next cycle, not same cycle).
REQ-025 Packets longer than DEPTH flits are a caller contract violation; behaviour undefined.

Reset
REQ-026 On noc_rst: pointers, packet counters, DROP flags, RR pointer (VC 0 first), pkt_drop_cnt cleared; FSM to IDLE; out_valid=0, err_code=0, vc_empty all 1, vc_full all 0 in the next cycle; FIFO contents discarded, array itself not reset.
REQ-027 Reset mid-packet SHALL discard all in-flight packets; no partial packet emitted afterwards.

Structure
REQ-028 Shared package nsu_pkg SHALL hold check-code constants, flit sideband field offsets, and the FSM state type.
REQ-029 One sub-module nsu_vc_flit_fifo (single per-VC FIFO with rollback) SHALL be instantiated VC_NUM times; arbiter/FSM stays in top.

Verification
REQ-030 Single 3-flit packet on VC2 (head code A, tail code C) -> out_vc=2, 3 flits in order, out_head on flit 0, out_tail on flit 2, first out_valid 1 cycle after tail write.
REQ-031 Tail-complete packets on VC0,1,3 simultaneously eligible, out_ready=1 -> emitted order 0,1,3, then next packet on VC0 after VC3.
REQ-032 Head with code 4'h5 on VC1 followed by 2 body+tail -> err_code pulse once, pkt_drop_cnt=1, nothing emitted, VC1 empty.
REQ-033 Fill VC0 with 16 flits (2 packets of 8), out_ready=0 -> in_ready low for VC0, high for VC1; release out_ready -> 16 flits out, vc_empty[0]=1.
REQ-034 out_ready toggled every cycle during 4-flit packet -> out_data stable while stalled, no flit duplicated or lost.
REQ-035 noc_rst asserted after 2 of 4 flits written on VC3 -> next cycle out_valid=0, vc_empty=4'hF; new packet afterwards delivered intact.

Source files
------------

// File: rtl/nsu_pkg.sv
// Shared definitions for the NoC slave-unit VC packet buffer: flit check codes,
// stored-flit sideband layout and the output FSM state type.
package nsu_pkg;

  localparam int CODE_W = 4;
  localparam logic [CODE_W-1:0] HEAD_CODE = 4'hA;
  localparam logic [CODE_W-1:0] TAIL_CODE = 4'hC;

  // Stored entry layout: {payload, tail, head}
  localparam int SB_HEAD = 0;
  localparam int SB_TAIL = 1;
  localparam int SB_W    = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } out_state_e;

endpackage

// File: rtl/nsu_vc_pack_buffer_if.sv
// Flit stream handshake: master drives flit + sideband + valid, slave drives ready.
interface nsu_vc_pack_buffer_if #(
  parameter int DATA_WIDTH = 128,
  parameter int VC_NUM     = 4
) ();

  localparam int VC_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  head;
  logic                  tail;
  logic [VC_W-1:0]       vc;
  logic                  ready;

  modport master (output data, valid, head, tail, vc, input ready);
  modport slave  (input data, valid, head, tail, vc, output ready);

endinterface

// File: rtl/nsu_vc_flit_fifo.sv
// Single-VC circular flit FIFO with packet-start rollback and a count of
// complete (tail-written) packets held.
module nsu_vc_flit_fifo
  import nsu_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    wr_head,
  input  logic                    wr_tail,
  input  logic                    rollback,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_head,
  output logic                    rd_tail,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  pkt_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = DATA_WIDTH + SB_W;

  logic [EW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, start_ptr;
  logic [EW-1:0] rd_entry;
  logic          tail_in, tail_out;

  assign rd_entry = mem[rd_ptr[AW-1:0]];
  assign rd_data  = rd_entry[EW-1:SB_W];
  assign rd_head  = rd_entry[SB_HEAD];
  assign rd_tail  = rd_entry[SB_TAIL];

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign tail_in  = wr_en && wr_tail && !rollback;
  assign tail_out = rd_en && rd_entry[SB_TAIL];

  // start_ptr marks the first slot of the packet currently being written
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      start_ptr <= '0;
      pkt_cnt   <= '0;
    end else begin
      if (rollback) begin
        wr_ptr <= start_ptr;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
        if (wr_tail) start_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
      case ({tail_in, tail_out})
        2'b10:   pkt_cnt <= pkt_cnt + (AW+1)'(1);
        2'b01:   pkt_cnt <= pkt_cnt - (AW+1)'(1);
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rollback) mem[wr_ptr[AW-1:0]] <= {wr_data, wr_tail, wr_head};
  end

endmodule

// File: rtl/nsu_vc_pack_buffer.sv
// Per-VC store-and-forward packet buffer: checks flit codes on write, drops
// malformed packets, and forwards whole packets with round-robin VC arbitration.
module nsu_vc_pack_buffer
  import nsu_pkg::*;
#(
  parameter int                DATA_WIDTH  = 128,
  parameter int                VC_NUM      = 4,
  parameter int                DEPTH       = 16,
  parameter logic [CODE_W-1:0] HEAD_CODE_H = HEAD_CODE,
  parameter logic [CODE_W-1:0] TAIL_CODE_H = TAIL_CODE
) (
  input  logic                  noc_clk,
  input  logic                  noc_rst,
  nsu_vc_pack_buffer_if.slave   in_flit,
  nsu_vc_pack_buffer_if.master  out_flit,
  output logic [VC_NUM-1:0]     vc_full,
  output logic [VC_NUM-1:0]     vc_empty,
  output logic                  err_code,
  output logic [15:0]           pkt_drop_cnt
);

  localparam int VC_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int CW   = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] fifo_data [VC_NUM];
  logic [CW-1:0]         pkt_cnt   [VC_NUM];
  logic [VC_NUM-1:0]     fifo_head, fifo_tail, eligible, drop, busy;
  logic [VC_W-1:0]       vc, lock_vc, rr_ptr, grant, sel_vc, idx;
  logic [CODE_W-1:0]     code;
  logic                  accept, bad, err, wr_ok;
  logic                  found, grant_take, out_valid, rd_fire;
  out_state_e            state, state_nx;

  assign vc            = in_flit.vc;
  assign code          = in_flit.data[DATA_WIDTH-1 -: CODE_W];
  assign in_flit.ready = ~vc_full[vc];
  assign accept        = in_flit.valid && in_flit.ready;

  // A single-flit packet is checked as a head, so it must carry the head code
  always_comb begin
    bad = 1'b0;
    if (in_flit.head)      bad = (code != HEAD_CODE_H) || busy[vc];
    else if (in_flit.tail) bad = (code != TAIL_CODE_H) || !busy[vc];
    else                   bad = !busy[vc];
  end

  assign err   = accept && !drop[vc] && bad;
  assign wr_ok = accept && !drop[vc] && !bad;

  for (genvar g = 0; g < VC_NUM; g++) begin : g_vc
    assign eligible[g] = (pkt_cnt[g] != '0);
    nsu_vc_flit_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
    ) u_fifo (
      .clk      (noc_clk),
      .rst      (noc_rst),
      .wr_en    (wr_ok && (vc == VC_W'(g))),
      .wr_data  (in_flit.data),
      .wr_head  (in_flit.head),
      .wr_tail  (in_flit.tail),
      .rollback (err && (vc == VC_W'(g))),
      .rd_en    (rd_fire && (sel_vc == VC_W'(g))),
      .rd_data  (fifo_data[g]),
      .rd_head  (fifo_head[g]),
      .rd_tail  (fifo_tail[g]),
      .full     (vc_full[g]),
      .empty    (vc_empty[g]),
      .pkt_cnt  (pkt_cnt[g])
    );
  end

  // Round-robin search starting at rr_ptr (the VC after the last grant)
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int i = 0; i < VC_NUM; i++) begin
      idx = rr_ptr + VC_W'(i);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    out_valid  = 1'b0;
    sel_vc     = lock_vc;
    grant_take = 1'b0;
    case (state)
      ST_IDLE: begin
        if (found) begin
          grant_take = 1'b1;
          sel_vc     = grant;
          out_valid  = 1'b1;
          state_nx   = (out_flit.ready && fifo_tail[grant]) ? ST_IDLE : ST_LOCK;
        end
      end
      ST_LOCK: begin
        out_valid = 1'b1;
        if (out_flit.ready && fifo_tail[lock_vc]) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign rd_fire        = out_valid && out_flit.ready;
  assign out_flit.valid = out_valid;
  assign out_flit.data  = fifo_data[sel_vc];
  assign out_flit.head  = fifo_head[sel_vc];
  assign out_flit.tail  = fifo_tail[sel_vc];
  assign out_flit.vc    = sel_vc;

  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      busy         <= '0;
      drop         <= '0;
      err_code     <= 1'b0;
      pkt_drop_cnt <= '0;
      state        <= ST_IDLE;
      lock_vc      <= '0;
      rr_ptr       <= '0;
    end else begin
      err_code <= err;
      if (err && (pkt_drop_cnt != 16'hFFFF)) pkt_drop_cnt <= pkt_drop_cnt + 16'd1;
      // An offending tail closes its own packet, so DROP is only held otherwise
      if (err) begin
        busy[vc] <= 1'b0;
        drop[vc] <= !in_flit.tail;
      end else if (accept && drop[vc]) begin
        if (in_flit.tail) drop[vc] <= 1'b0;
      end else if (wr_ok) begin
        busy[vc] <= !in_flit.tail;
      end
      state <= state_nx;
      if (grant_take) begin
        lock_vc <= grant;
        rr_ptr  <= grant + VC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_nsu_vc_pack_buffer.sv
// Directed bench for nsu_vc_pack_buffer: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_nsu_vc_pack_buffer;

  localparam int DW = 128;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  vc_full, vc_empty;
  logic        err_code;
  logic [15:0] pkt_drop_cnt;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [15:0] pl;
    logic        h;
    logic        t;
    logic [1:0]  vc;
  } obs_t;
  obs_t mon_q[$];

  nsu_vc_pack_buffer_if #(.DATA_WIDTH(DW), .VC_NUM(4)) in_bus ();
  nsu_vc_pack_buffer_if #(.DATA_WIDTH(DW), .VC_NUM(4)) out_bus ();

  nsu_vc_pack_buffer #(.DATA_WIDTH(DW), .VC_NUM(4), .DEPTH(16)) dut (
    .noc_clk      (clk),
    .noc_rst      (rst),
    .in_flit      (in_bus),
    .out_flit     (out_bus),
    .vc_full      (vc_full),
    .vc_empty     (vc_empty),
    .err_code     (err_code),
    .pkt_drop_cnt (pkt_drop_cnt)
  );

  always #5 clk = ~clk;

  // Inputs only change #1 after posedge, so the negedge view is what the next edge accepts
  always @(negedge clk) begin
    if (!rst && out_bus.valid && out_bus.ready)
      mon_q.push_back('{out_bus.data[15:0], out_bus.head, out_bus.tail, out_bus.vc});
  end

  function automatic logic [DW-1:0] mk(input logic [3:0] code, input logic [15:0] pl);
    logic [DW-1:0] r;
    r = '0;
    r[DW-1 -: 4] = code;
    r[15:0] = pl;
    return r;
  endfunction

  task automatic apply_reset();
    in_bus.valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mon_q.delete();
  endtask

  task automatic send(input logic [1:0] vc, input logic h, input logic t,
                      input logic [3:0] code, input logic [15:0] pl);
    in_bus.data  = mk(code, pl);
    in_bus.vc    = vc;
    in_bus.head  = h;
    in_bus.tail  = t;
    in_bus.valid = 1'b1;
    @(posedge clk);
    #1;
    in_bus.valid = 1'b0;
    in_bus.head  = 1'b0;
    in_bus.tail  = 1'b0;
  endtask

  task automatic test_reset();
    out_bus.ready = 1'b1;
    in_bus.vc = 2'd0;
    apply_reset();
    checks++; if (out_bus.valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_bus.valid); end
    checks++; if (vc_empty !== 4'hF) begin errors++; $display("FAIL reset_vc_empty: got %0h want f", vc_empty); end
    checks++; if (vc_full !== 4'h0) begin errors++; $display("FAIL reset_vc_full: got %0h want 0", vc_full); end
    checks++; if (err_code !== 1'b0) begin errors++; $display("FAIL reset_err_code: got %0b want 0", err_code); end
    checks++; if (pkt_drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop_cnt: got %0d want 0", pkt_drop_cnt); end
    checks++; if (in_bus.ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_bus.ready); end
  endtask

  task automatic test_single_packet();
    logic [15:0] exp_pl [3] = '{16'h0021, 16'h0022, 16'h0023};
    apply_reset();
    out_bus.ready = 1'b1;
    send(2'd2, 1'b1, 1'b0, 4'hA, 16'h0021);
    send(2'd2, 1'b0, 1'b0, 4'h0, 16'h0022);
    checks++; if (out_bus.valid !== 1'b0) begin errors++; $display("FAIL single_no_early_valid: got %0b want 0", out_bus.valid); end
    send(2'd2, 1'b0, 1'b1, 4'hC, 16'h0023);
    checks++; if (out_bus.valid !== 1'b1 || out_bus.head !== 1'b1 || out_bus.vc !== 2'd2)
      begin errors++; $display("FAIL single_latency: got valid=%0b head=%0b vc=%0d want 1 1 2", out_bus.valid, out_bus.head, out_bus.vc); end
    for (int i = 0; i < 50 && mon_q.size() < 3; i++) @(posedge clk);
    #1;
    checks++; if (mon_q.size() !== 3) begin errors++; $display("FAIL single_count: got %0d want 3", mon_q.size()); end
    for (int i = 0; i < 3 && i < mon_q.size(); i++) begin
      checks++;
      if (mon_q[i].pl !== exp_pl[i] || mon_q[i].vc !== 2'd2 || mon_q[i].h !== (i == 0) || mon_q[i].t !== (i == 2))
        begin errors++; $display("FAIL single_flit%0d: got pl=%0h vc=%0d h=%0b t=%0b want pl=%0h vc=2 h=%0b t=%0b",
                                 i, mon_q[i].pl, mon_q[i].vc, mon_q[i].h, mon_q[i].t, exp_pl[i], i == 0, i == 2); end
    end
    checks++; if (vc_empty !== 4'hF) begin errors++; $display("FAIL single_empty_after: got %0h want f", vc_empty); end
  endtask

  task automatic test_round_robin();
    logic [15:0] exp_pl [8] = '{16'h01, 16'h02, 16'h11, 16'h12, 16'h31, 16'h32, 16'h05, 16'h06};
    logic [1:0]  exp_vc [8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd3, 2'd3, 2'd0, 2'd0};
    apply_reset();
    out_bus.ready = 1'b0;
    send(2'd0, 1'b1, 1'b0, 4'hA, 16'h01); send(2'd0, 1'b0, 1'b1, 4'hC, 16'h02);
    send(2'd1, 1'b1, 1'b0, 4'hA, 16'h11); send(2'd1, 1'b0, 1'b1, 4'hC, 16'h12);
    send(2'd3, 1'b1, 1'b0, 4'hA, 16'h31); send(2'd3, 1'b0, 1'b1, 4'hC, 16'h32);
    send(2'd0, 1'b1, 1'b0, 4'hA, 16'h05); send(2'd0, 1'b0, 1'b1, 4'hC, 16'h06);
    out_bus.ready = 1'b1;
    for (int i = 0; i < 60 && mon_q.size() < 8; i++) @(posedge clk);
    #1;
    checks++; if (mon_q.size() !== 8) begin errors++; $display("FAIL rr_count: got %0d want 8", mon_q.size()); end
    for (int i = 0; i < 8 && i < mon_q.size(); i++) begin
      checks++;
      if (mon_q[i].pl !== exp_pl[i] || mon_q[i].vc !== exp_vc[i])
        begin errors++; $display("FAIL rr_order%0d: got pl=%0h vc=%0d want pl=%0h vc=%0d", i, mon_q[i].pl, mon_q[i].vc, exp_pl[i], exp_vc[i]); end
    end
  endtask

  task automatic test_drop();
    apply_reset();
    out_bus.ready = 1'b1;
    send(2'd1, 1'b1, 1'b0, 4'h5, 16'h0051);
    checks++; if (err_code !== 1'b1) begin errors++; $display("FAIL drop_err_pulse: got %0b want 1", err_code); end
    send(2'd1, 1'b0, 1'b0, 4'h0, 16'h0052);
    checks++; if (err_code !== 1'b0) begin errors++; $display("FAIL drop_err_once: got %0b want 0", err_code); end
    send(2'd1, 1'b0, 1'b1, 4'hC, 16'h0053);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (pkt_drop_cnt !== 16'd1) begin errors++; $display("FAIL drop_cnt: got %0d want 1", pkt_drop_cnt); end
    checks++; if (mon_q.size() !== 0) begin errors++; $display("FAIL drop_emitted: got %0d want 0", mon_q.size()); end
    checks++; if (vc_empty[1] !== 1'b1) begin errors++; $display("FAIL drop_vc1_empty: got %0b want 1", vc_empty[1]); end
    // Second head mid-packet: partial packet must be rolled back
    send(2'd1, 1'b1, 1'b0, 4'hA, 16'h0041);
    send(2'd1, 1'b0, 1'b0, 4'h0, 16'h0042);
    send(2'd1, 1'b1, 1'b0, 4'hA, 16'h0043);
    checks++; if (err_code !== 1'b1) begin errors++; $display("FAIL drop_midpkt_err: got %0b want 1", err_code); end
    send(2'd1, 1'b0, 1'b1, 4'hC, 16'h0044);
    checks++; if (vc_empty[1] !== 1'b1) begin errors++; $display("FAIL drop_rollback_empty: got %0b want 1", vc_empty[1]); end
    send(2'd1, 1'b1, 1'b0, 4'hA, 16'h0045);
    send(2'd1, 1'b0, 1'b1, 4'hC, 16'h0046);
    for (int i = 0; i < 30 && mon_q.size() < 2; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (pkt_drop_cnt !== 16'd2) begin errors++; $display("FAIL drop_cnt2: got %0d want 2", pkt_drop_cnt); end
    checks++;
    if (mon_q.size() !== 2 || mon_q[0].pl !== 16'h0045 || mon_q[1].pl !== 16'h0046)
      begin errors++; $display("FAIL drop_recover: got %0d flits first=%0h want 2 flits 45,46", mon_q.size(), (mon_q.size() > 0) ? mon_q[0].pl : 16'hx); end
  endtask

  task automatic test_full();
    apply_reset();
    out_bus.ready = 1'b0;
    for (int i = 0; i < 16; i++)
      send(2'd0, (i % 8) == 0, (i % 8) == 7, ((i % 8) == 0) ? 4'hA : (((i % 8) == 7) ? 4'hC : 4'h0), 16'(i));
    in_bus.vc = 2'd0;
    #1;
    checks++; if (in_bus.ready !== 1'b0) begin errors++; $display("FAIL full_ready_vc0: got %0b want 0", in_bus.ready); end
    checks++; if (vc_full !== 4'h1) begin errors++; $display("FAIL full_vc_full: got %0h want 1", vc_full); end
    in_bus.vc = 2'd1;
    #1;
    checks++; if (in_bus.ready !== 1'b1) begin errors++; $display("FAIL full_ready_vc1: got %0b want 1", in_bus.ready); end
    @(posedge clk); #1;
    out_bus.ready = 1'b1;
    for (int i = 0; i < 80 && mon_q.size() < 16; i++) @(posedge clk);
    #1;
    checks++; if (mon_q.size() !== 16) begin errors++; $display("FAIL full_count: got %0d want 16", mon_q.size()); end
    for (int i = 0; i < 16 && i < mon_q.size(); i++) begin
      checks++;
      if (mon_q[i].pl !== 16'(i) || mon_q[i].vc !== 2'd0)
        begin errors++; $display("FAIL full_flit%0d: got pl=%0h vc=%0d want pl=%0h vc=0", i, mon_q[i].pl, mon_q[i].vc, i); end
    end
    checks++; if (vc_empty[0] !== 1'b1) begin errors++; $display("FAIL full_drained: got %0b want 1", vc_empty[0]); end
  endtask

  task automatic test_stall();
    logic [DW-1:0] held;
    logic          stalled;
    apply_reset();
    out_bus.ready = 1'b0;
    send(2'd2, 1'b1, 1'b0, 4'hA, 16'h0061);
    send(2'd2, 1'b0, 1'b0, 4'h0, 16'h0062);
    send(2'd2, 1'b0, 1'b0, 4'h0, 16'h0063);
    send(2'd2, 1'b0, 1'b1, 4'hC, 16'h0064);
    held = '0;
    stalled = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (stalled) begin
        checks++;
        if (out_bus.valid !== 1'b1 || out_bus.data !== held)
          begin errors++; $display("FAIL stall_stable: got valid=%0b data=%0h want 1 %0h", out_bus.valid, out_bus.data[15:0], held[15:0]); end
      end
      out_bus.ready = ~out_bus.ready;
      stalled = out_bus.valid && !out_bus.ready;
      held = out_bus.data;
      @(posedge clk); #1;
    end
    checks++; if (mon_q.size() !== 4) begin errors++; $display("FAIL stall_count: got %0d want 4", mon_q.size()); end
    for (int i = 0; i < 4 && i < mon_q.size(); i++) begin
      checks++;
      if (mon_q[i].pl !== 16'h0061 + 16'(i))
        begin errors++; $display("FAIL stall_flit%0d: got %0h want %0h", i, mon_q[i].pl, 16'h0061 + 16'(i)); end
    end
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    out_bus.ready = 1'b1;
    send(2'd3, 1'b1, 1'b0, 4'hA, 16'h0071);
    send(2'd3, 1'b0, 1'b0, 4'h0, 16'h0072);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_bus.valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %0b want 0", out_bus.valid); end
    checks++; if (vc_empty !== 4'hF) begin errors++; $display("FAIL rstmid_empty: got %0h want f", vc_empty); end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (mon_q.size() !== 0) begin errors++; $display("FAIL rstmid_partial: got %0d want 0", mon_q.size()); end
    send(2'd3, 1'b1, 1'b0, 4'hA, 16'h0081);
    send(2'd3, 1'b0, 1'b0, 4'h0, 16'h0082);
    send(2'd3, 1'b0, 1'b0, 4'h0, 16'h0083);
    send(2'd3, 1'b0, 1'b1, 4'hC, 16'h0084);
    for (int i = 0; i < 30 && mon_q.size() < 4; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (mon_q.size() !== 4) begin errors++; $display("FAIL rstmid_count: got %0d want 4", mon_q.size()); end
    for (int i = 0; i < 4 && i < mon_q.size(); i++) begin
      checks++;
      if (mon_q[i].pl !== 16'h0081 + 16'(i) || mon_q[i].vc !== 2'd3 || mon_q[i].h !== (i == 0) || mon_q[i].t !== (i == 3))
        begin errors++; $display("FAIL rstmid_flit%0d: got pl=%0h vc=%0d h=%0b t=%0b", i, mon_q[i].pl, mon_q[i].vc, mon_q[i].h, mon_q[i].t); end
    end
  endtask

  initial begin
    in_bus.valid  = 1'b0;
    in_bus.head   = 1'b0;
    in_bus.tail   = 1'b0;
    in_bus.vc     = 2'd0;
    in_bus.data   = '0;
    out_bus.ready = 1'b0;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_drop();
    test_full();
    test_stall();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
